// File: rtl/eusci_baud_gen.sv
// eUSCI UART baud-rate generator.
// Divides BRCLK into the BITCLK bit strobe and the BITCLK16 oversampling
// strobe, with UCBRx division, UCBRFx first-stage modulation (oversampling
// mode) and UCBRSx second-stage per-bit modulation aligned to frame start.
// The configuration is captured at the clock edge that opens each bit
// period, so the length of every period is known before its first cycle
// and all strobes can come straight from flops.
module eusci_baud_gen (
    input  logic        BRCLK,
    input  logic        reset,
    input  logic        wUCSWRST,
    input  logic        wUCOS16,
    input  logic [15:0] wUCBR,
    input  logic [3:0]  wUCBRF,
    input  logic [7:0]  wUCBRS,
    input  logic        TxBusy,
    output logic        BITCLK,
    output logic        BITCLK16,
    output logic [2:0]  modIdx
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        os16_q, os16_d;
    logic [16:0] n_q, n_d;
    logic [3:0]  brf_q, brf_d;
    logic        m_q, m_d;
    logic [3:0]  tick_q, tick_d;
    logic [16:0] cyc_q, cyc_d;
    logic [16:0] len_q, len_d;
    logic [2:0]  mod_q, mod_d;
    logic        bitclk_q, bitclk_d;
    logic        bitclk16_q, bitclk16_d;
    logic        new_period_s;

    // Length in BRCLK cycles of tick t; in low-frequency mode the whole
    // period is tick 0, so this collapses to N + m.
    function automatic logic [16:0] tick_len(
        input logic        os,
        input logic [16:0] n,
        input logic [3:0]  brf,
        input logic        m,
        input logic [3:0]  t
    );
        logic [16:0] len;
        len = n;
        if (os && (t < brf)) begin
            len = len + 17'd1;
        end else begin
            len = len + 17'd0;
        end
        if ((t == 4'd0) && m) begin
            len = len + 17'd1;
        end else begin
            len = len + 17'd0;
        end
        return len;
    endfunction

    // Next-state logic: open a new period, advance a tick, or count a cycle.
    always_comb begin
        state_d      = ST_RUN;
        os16_d       = os16_q;
        n_d          = n_q;
        brf_d        = brf_q;
        m_d          = m_q;
        tick_d       = tick_q;
        cyc_d        = cyc_q;
        len_d        = len_q;
        mod_d        = mod_q;
        new_period_s = (state_q == ST_IDLE) || bitclk_q;

        if (new_period_s) begin
            // TxBusy seen in the BITCLK cycle is the transmitter's pre-edge
            // state; an idle transmitter means the next bit is a start bit.
            if (state_q == ST_IDLE) begin
                mod_d = 3'd0;
            end else if (TxBusy) begin
                mod_d = mod_q + 3'd1;
            end else begin
                mod_d = 3'd0;
            end
            os16_d = wUCOS16;
            n_d    = (wUCBR == 16'd0) ? 17'd1 : {1'b0, wUCBR};
            brf_d  = wUCBRF;
            m_d    = wUCBRS[mod_d];
            tick_d = 4'd0;
            cyc_d  = 17'd1;
            len_d  = tick_len(os16_d, n_d, brf_d, m_d, 4'd0);
        end else if (bitclk16_q) begin
            tick_d = tick_q + 4'd1;
            cyc_d  = 17'd1;
            len_d  = tick_len(os16_q, n_q, brf_q, m_q, tick_d);
        end else begin
            cyc_d  = cyc_q + 17'd1;
        end

        bitclk16_d = (cyc_d == len_d);
        bitclk_d   = bitclk16_d && (!os16_d || (tick_d == 4'd15));
    end

    // State and output registers; software reset aborts the period at once.
    always_ff @(posedge BRCLK or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            os16_q     <= 1'b0;
            n_q        <= 17'd1;
            brf_q      <= 4'd0;
            m_q        <= 1'b0;
            tick_q     <= 4'd0;
            cyc_q      <= 17'd0;
            len_q      <= 17'd1;
            mod_q      <= 3'd0;
            bitclk_q   <= 1'b0;
            bitclk16_q <= 1'b0;
        end else if (wUCSWRST) begin
            state_q    <= ST_IDLE;
            os16_q     <= 1'b0;
            n_q        <= 17'd1;
            brf_q      <= 4'd0;
            m_q        <= 1'b0;
            tick_q     <= 4'd0;
            cyc_q      <= 17'd0;
            len_q      <= 17'd1;
            mod_q      <= 3'd0;
            bitclk_q   <= 1'b0;
            bitclk16_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            os16_q     <= os16_d;
            n_q        <= n_d;
            brf_q      <= brf_d;
            m_q        <= m_d;
            tick_q     <= tick_d;
            cyc_q      <= cyc_d;
            len_q      <= len_d;
            mod_q      <= mod_d;
            bitclk_q   <= bitclk_d;
            bitclk16_q <= bitclk16_d;
        end
    end

    assign BITCLK   = bitclk_q;
    assign BITCLK16 = bitclk16_q;
    assign modIdx   = mod_q;

endmodule

// File: tb/tb_eusci_baud_gen.sv
// Scoreboard bench for eusci_baud_gen: stimulus pushes the expected strobe
// events (gap since previous strobe, BITCLK, modIdx); a monitor pops and
// compares on every BITCLK16.
module tb_eusci_baud_gen;

    logic        BRCLK = 1'b0;
    logic        reset = 1'b1;
    logic        wUCSWRST = 1'b1;
    logic        wUCOS16 = 1'b0;
    logic [15:0] wUCBR = 16'd1;
    logic [3:0]  wUCBRF = 4'd0;
    logic [7:0]  wUCBRS = 8'd0;
    logic        TxBusy = 1'b0;
    logic        BITCLK;
    logic        BITCLK16;
    logic [2:0]  modIdx;

    typedef struct {
        int         gap;
        logic       bc;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;
    logic act = 1'b0;
    int   gap = 0;

    eusci_baud_gen dut (
        .BRCLK    (BRCLK),
        .reset    (reset),
        .wUCSWRST (wUCSWRST),
        .wUCOS16  (wUCOS16),
        .wUCBR    (wUCBR),
        .wUCBRF   (wUCBRF),
        .wUCBRS   (wUCBRS),
        .TxBusy   (TxBusy),
        .BITCLK   (BITCLK),
        .BITCLK16 (BITCLK16),
        .modIdx   (modIdx)
    );

    always #5 BRCLK = ~BRCLK;

    // A cycle is active when the DUT saw neither reset at its opening edge.
    initial begin
        forever begin
            @(posedge BRCLK);
            act = !reset && !wUCSWRST;
        end
    end

    // Monitor: count active cycles, compare each strobe against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge BRCLK);
            if (reset || !act) begin
                gap = 0;
                n_cmp++;
                if (BITCLK !== 1'b0 || BITCLK16 !== 1'b0 || modIdx !== 3'd0) begin
                    n_fail++;
                    $display("FAIL inactive_out: got BITCLK=%b BITCLK16=%b modIdx=%0d, want 0/0/0",
                             BITCLK, BITCLK16, modIdx);
                end
            end else begin
                gap++;
                if (BITCLK16 === 1'b1) begin
                    if (chk_en) begin
                        n_cmp++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_strobe: got strobe at t=%0t, want none", $time);
                        end else begin
                            e = q.pop_front();
                            if (gap != e.gap || BITCLK !== e.bc || modIdx !== e.idx) begin
                                n_fail++;
                                $display("FAIL strobe t=%0t: got gap=%0d BITCLK=%b modIdx=%0d, want gap=%0d BITCLK=%b modIdx=%0d",
                                         $time, gap, BITCLK, modIdx, e.gap, e.bc, e.idx);
                            end
                        end
                    end
                    gap = 0;
                end else if (chk_en) begin
                    n_cmp++;
                    if (BITCLK !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bitclk_alone t=%0t: got BITCLK=1 without BITCLK16, want 0", $time);
                    end
                end
            end
        end
    end

    task automatic push_ev(input int g, input logic bc, input logic [2:0] idx);
        exp_t e;
        e.gap = g;
        e.bc  = bc;
        e.idx = idx;
        q.push_back(e);
    endtask

    task automatic start_run(input logic os, input logic [15:0] br, input logic [3:0] brf,
                             input logic [7:0] brs, input logic busy);
        @(posedge BRCLK);
        #2;
        wUCOS16  = os;
        wUCBR    = br;
        wUCBRF   = brf;
        wUCBRS   = brs;
        TxBusy   = busy;
        chk_en   = 1'b1;
        wUCSWRST = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int limit);
        int k;
        k = 0;
        while (q.size() != 0 && k < limit) begin
            @(posedge BRCLK);
            #2;
            k++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d events outstanding, want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic stop_run();
        chk_en   = 1'b0;
        wUCSWRST = 1'b1;
        repeat (3) @(posedge BRCLK);
        #2;
    endtask

    initial begin
        int k;
        bit found;

        // Reset state
        repeat (3) @(posedge BRCLK);
        #2;
        n_cmp++;
        if (BITCLK !== 1'b0 || BITCLK16 !== 1'b0 || modIdx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b/%b/%0d, want 0/0/0", BITCLK, BITCLK16, modIdx);
        end
        reset = 1'b0;
        repeat (2) @(posedge BRCLK);

        // LF, N=6, no modulation, idle transmitter: period 6, modIdx 0
        for (int i = 0; i < 4; i++) push_ev(6, 1'b1, 3'd0);
        start_run(1'b0, 16'd6, 4'd0, 8'h00, 1'b0);
        wait_empty("lf_plain", 100);
        stop_run();

        // LF, N=6, UCBRS=0x01, busy: periods 7,6x7,7,6 with modIdx 0..7,0,1
        for (int i = 0; i < 10; i++) push_ev((i % 8 == 0) ? 7 : 6, 1'b1, 3'(i % 8));
        start_run(1'b0, 16'd6, 4'd0, 8'h01, 1'b1);
        wait_empty("lf_mod", 200);
        stop_run();

        // OS16, N=1, UCBRF=4: ticks 2,2,2,2 then 1x12; bit period 20
        for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 16; t++) push_ev((t < 4) ? 2 : 1, (t == 15), 3'd0);
        end
        start_run(1'b1, 16'd1, 4'd4, 8'h00, 1'b0);
        wait_empty("os16", 200);
        stop_run();

        // UCBR=0 in LF behaves as N=1: BITCLK every cycle
        for (int i = 0; i < 5; i++) push_ev(1, 1'b1, 3'd0);
        start_run(1'b0, 16'd0, 4'd0, 8'h00, 1'b0);
        wait_empty("ucbr0", 50);
        stop_run();

        // Mid-period async reset three cycles into a 6-cycle period
        push_ev(6, 1'b1, 3'd0);
        start_run(1'b0, 16'd6, 4'd0, 8'h00, 1'b1);
        wait_empty("midrst_pre", 50);
        n_cmp++;
        if (modIdx !== 3'd1) begin
            n_fail++;
            $display("FAIL midrst_idx_before: got modIdx=%0d, want 1", modIdx);
        end
        repeat (2) @(posedge BRCLK);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (BITCLK !== 1'b0 || BITCLK16 !== 1'b0 || modIdx !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b/%b/%0d, want 0/0/0", BITCLK, BITCLK16, modIdx);
        end
        push_ev(6, 1'b1, 3'd0);
        push_ev(6, 1'b1, 3'd1);
        repeat (2) @(posedge BRCLK);
        #2;
        reset = 1'b0;
        wait_empty("midrst_post", 50);
        stop_run();

        // Frame alignment: TxBusy low at the modIdx=3 BITCLK restarts the
        // frame; UCBRS=0x80 lengthens only the 8th bit
        for (int i = 0; i < 4; i++) push_ev(2, 1'b1, 3'(i));
        for (int i = 0; i < 8; i++) push_ev((i == 7) ? 3 : 2, 1'b1, 3'(i));
        push_ev(2, 1'b1, 3'd0);
        start_run(1'b0, 16'd2, 4'd0, 8'h80, 1'b1);
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            @(negedge BRCLK);
            #1;
            if (BITCLK === 1'b1 && modIdx === 3'd3) found = 1'b1;
            k++;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL frame_sync: got no BITCLK with modIdx=3, want one");
        end
        TxBusy = 1'b0;
        @(posedge BRCLK);
        #2;
        TxBusy = 1'b1;
        wait_empty("frame", 100);
        stop_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
